// File: rtl/adder_bist.sv
`default_nettype none
// ============================================================================
// Module      : adder_bist
// Description : Built-in self-test engine for an N-bit adder tile. Sweeps
//               every operand combination into the adder under test, waits
//               DUT_LAT cycles per vector, compares {cout,sum} against an
//               internal reference and reports error count, first failing
//               vector and pass/fail.
//               Optional feature macro: BIST_CIN_EN (include carry-in in the
//               sweep; otherwise op_cin is tied to 0).
// Revision    : 1.0 - initial release
// ============================================================================
module adder_bist #(
   parameter int WIDTH   = 4,   // operand width of the adder under test (1..8)
   parameter int DUT_LAT = 1,   // cycles from operand change to valid result
   parameter int ERR_W   = 8    // width of the saturating error counter
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_start,
   output logic [WIDTH-1:0]   o_op_a,
   output logic [WIDTH-1:0]   o_op_b,
   output logic               o_op_cin,
   input  logic [WIDTH-1:0]   i_dut_sum,
   input  logic               i_dut_cout,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_pass,
   output logic [ERR_W-1:0]   o_err_count,
   output logic               o_fail_valid,
   output logic [2*WIDTH:0]   o_fail_vec
);

`ifdef BIST_CIN_EN
   localparam int c_VEC_W = 2*WIDTH + 1;
`else
   localparam int c_VEC_W = 2*WIDTH;
`endif
   localparam int c_WAIT_W = (DUT_LAT > 0) ? $clog2(DUT_LAT + 1) : 1;
   localparam logic [c_VEC_W-1:0]  c_VEC_LAST  = '1;
   localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(DUT_LAT);
   localparam logic [ERR_W-1:0]    c_ERR_MAX   = '1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [c_VEC_W-1:0]   r_vec;
   logic [c_WAIT_W-1:0]  r_wait;
   logic [ERR_W-1:0]     r_err_count;
   logic                 r_fail_valid;
   logic [2*WIDTH:0]     r_fail_vec;

   logic                 w_clear;
   logic                 w_compare;
   logic                 w_busy;
   logic                 w_done;
   logic                 w_cin;
   logic [WIDTH:0]       w_ref;
   logic                 w_mismatch;
   logic [2*WIDTH:0]     w_cur_vec;

   // Operands come straight off the vector register, so they are registered
   // and read 0 in IDLE (vector register is cleared by reset).
   assign o_op_a = r_vec[WIDTH-1:0];
   assign o_op_b = r_vec[2*WIDTH-1:WIDTH];
`ifdef BIST_CIN_EN
   assign w_cin  = r_vec[2*WIDTH];
`else
   assign w_cin  = 1'b0;
`endif
   assign o_op_cin = w_cin;

   // Reference is computed one bit wider than the operands so the carry-out
   // is never truncated.
   assign w_ref      = {1'b0, o_op_a} + {1'b0, o_op_b} + {{WIDTH{1'b0}}, w_cin};
   assign w_mismatch = ({i_dut_cout, i_dut_sum} != w_ref);
   assign w_cur_vec  = {w_cin, o_op_b, o_op_a};

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode plus clear/compare strobes and status decode.
   always_comb begin
      w_state_nxt = r_state;
      w_clear     = 1'b0;
      w_compare   = 1'b0;
      w_busy      = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_state_nxt = S_RUN;
               w_clear     = 1'b1;
            end
         end
         S_RUN: begin
            w_busy = 1'b1;
            if (r_wait == c_WAIT_LAST) begin
               w_compare = 1'b1;
               if (r_vec == c_VEC_LAST) begin
                  w_state_nxt = S_DONE;
               end
            end
         end
         S_DONE: begin
            w_done = 1'b1;
            if (i_start) begin
               w_state_nxt = S_RUN;
               w_clear     = 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Sweep datapath: vector/wait counters, saturating error count, first-fail capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vec        <= '0;
         r_wait       <= '0;
         r_err_count  <= '0;
         r_fail_valid <= 1'b0;
         r_fail_vec   <= '0;
      end else if (w_clear) begin
         r_vec        <= '0;
         r_wait       <= '0;
         r_err_count  <= '0;
         r_fail_valid <= 1'b0;
         r_fail_vec   <= '0;
      end else if (w_busy) begin
         if (w_compare) begin
            if (w_mismatch) begin
               if (r_err_count != c_ERR_MAX) begin
                  r_err_count <= r_err_count + ERR_W'(1);
               end
               if (!r_fail_valid) begin
                  r_fail_valid <= 1'b1;
                  r_fail_vec   <= w_cur_vec;
               end
            end
            // Last vector stays on the operands through DONE.
            if (r_vec != c_VEC_LAST) begin
               r_vec  <= r_vec + c_VEC_W'(1);
               r_wait <= '0;
            end
         end else begin
            r_wait <= r_wait + c_WAIT_W'(1);
         end
      end
   end

   assign o_busy       = w_busy;
   assign o_done       = w_done;
   assign o_pass       = w_done && (r_err_count == '0);
   assign o_err_count  = r_err_count;
   assign o_fail_valid = r_fail_valid;
   assign o_fail_vec   = r_fail_vec;

endmodule
`default_nettype wire

// File: tb/tb_adder_bist.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_adder_bist
// Description : Directed self-checking bench for adder_bist (WIDTH=4,
//               DUT_LAT=1). A registered behavioural adder with selectable
//               faults stands in for the tile under test. A second instance
//               with ERR_W=4 exercises counter saturation. Expectations
//               follow BIST_CIN_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_bist;

   localparam int WIDTH   = 4;
   localparam int DUT_LAT = 1;

`ifdef BIST_CIN_EN
   localparam int         N_VEC      = 512;
   localparam int         N_SUM0     = 256;
   localparam int         N_COUT1    = 255;   // 256 mismatches, 8-bit counter saturates
   localparam int         N_CINIGN   = 256;
   localparam logic [8:0] FV_CINIGN  = 9'h100;
`else
   localparam int         N_VEC      = 256;
   localparam int         N_SUM0     = 128;
   localparam int         N_COUT1    = 136;   // pairs with a+b < 16
   localparam int         N_CINIGN   = 0;
   localparam logic [8:0] FV_CINIGN  = 9'h000;
`endif
   localparam int SWEEP = N_VEC * (DUT_LAT + 1);

   logic             clk;
   logic             rst;
   logic             start;
   int               fault;    // 0 ok, 1 sum[0] sa0, 2 cout sa1, 3 ignore cin

   logic [WIDTH-1:0] op_a, op_b, dut_sum;
   logic             op_cin, dut_cout;
   logic             busy, done, pass, fail_valid;
   logic [7:0]       err_count;
   logic [8:0]       fail_vec;

   logic [WIDTH-1:0] op_a_s, op_b_s, dut_sum_s;
   logic             op_cin_s, dut_cout_s;
   logic             busy_s, done_s, pass_s, fail_valid_s;
   logic [3:0]       err_count_s;
   logic [8:0]       fail_vec_s;

   logic [WIDTH:0]   m_res, m_res_s;

   int n_checks = 0;
   int n_errors = 0;

   adder_bist #(.WIDTH(WIDTH), .DUT_LAT(DUT_LAT), .ERR_W(8)) u_dut (
      .clk(clk), .rst(rst), .i_start(start),
      .o_op_a(op_a), .o_op_b(op_b), .o_op_cin(op_cin),
      .i_dut_sum(dut_sum), .i_dut_cout(dut_cout),
      .o_busy(busy), .o_done(done), .o_pass(pass),
      .o_err_count(err_count), .o_fail_valid(fail_valid), .o_fail_vec(fail_vec)
   );

   adder_bist #(.WIDTH(WIDTH), .DUT_LAT(DUT_LAT), .ERR_W(4)) u_dut_sat (
      .clk(clk), .rst(rst), .i_start(start),
      .o_op_a(op_a_s), .o_op_b(op_b_s), .o_op_cin(op_cin_s),
      .i_dut_sum(dut_sum_s), .i_dut_cout(dut_cout_s),
      .o_busy(busy_s), .o_done(done_s), .o_pass(pass_s),
      .o_err_count(err_count_s), .o_fail_valid(fail_valid_s), .o_fail_vec(fail_vec_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [WIDTH:0] add_model(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic cin);
      return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, (fault == 3) ? 1'b0 : cin};
   endfunction

   // One-cycle-latency adder tiles under test.
   always @(posedge clk) begin
      m_res   <= add_model(op_a, op_b, op_cin);
      m_res_s <= add_model(op_a_s, op_b_s, op_cin_s);
   end

   assign dut_sum    = (fault == 1) ? (m_res[WIDTH-1:0] & 4'b1110) : m_res[WIDTH-1:0];
   assign dut_cout   = (fault == 2) ? 1'b1 : m_res[WIDTH];
   assign dut_sum_s  = (fault == 1) ? (m_res_s[WIDTH-1:0] & 4'b1110) : m_res_s[WIDTH-1:0];
   assign dut_cout_s = (fault == 2) ? 1'b1 : m_res_s[WIDTH];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Launch a sweep and count busy cycles until done; optionally keep start high.
   task automatic run_sweep(input bit hold_start, output int cycles);
      bit pass_seen;
      pass_seen = 1'b0;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1;
      if (!hold_start) start = 1'b0;
      cycles = 0;
      while (busy === 1'b1 && cycles < 4*SWEEP) begin
         cycles++;
         if (pass === 1'b1) pass_seen = 1'b1;
         @(posedge clk); #1;
      end
      check("pass_while_busy", 32'(pass_seen), 0);
      check("busy_fell", 32'(busy), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      rst   = 1'b1;
      start = 1'b0;
      fault = 0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;

      // Reset state
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_pass", 32'(pass), 0);
      check("rst_err", 32'(err_count), 0);
      check("rst_fv", 32'(fail_valid), 0);
      check("rst_fvec", 32'(fail_vec), 0);
      check("rst_op_a", 32'(op_a), 0);
      check("rst_op_b", 32'(op_b), 0);
      check("rst_op_cin", 32'(op_cin), 0);

      // Correct adder
      fault = 0;
      run_sweep(1'b0, cyc);
      check("ok_cycles", 32'(cyc), SWEEP);
      check("ok_done", 32'(done), 1);
      check("ok_pass", 32'(pass), 1);
      check("ok_err", 32'(err_count), 0);
      check("ok_fv", 32'(fail_valid), 0);
      check("ok_op_a_held", 32'(op_a), 32'hF);
      check("ok_op_b_held", 32'(op_b), 32'hF);

      // sum[0] stuck-at-0
      fault = 1;
      run_sweep(1'b0, cyc);
      check("sa0_cycles", 32'(cyc), SWEEP);
      check("sa0_err", 32'(err_count), N_SUM0);
      check("sa0_fv", 32'(fail_valid), 1);
      check("sa0_fvec", 32'(fail_vec), 32'h001);
      check("sa0_pass", 32'(pass), 0);
      check("sa0_done", 32'(done), 1);

      // cout stuck-at-1: saturation on both counters
      fault = 2;
      run_sweep(1'b0, cyc);
      check("sa1_err", 32'(err_count), N_COUT1);
      check("sa1_fvec", 32'(fail_vec), 0);
      check("sat_err", 32'(err_count_s), 15);
      check("sat_fv", 32'(fail_valid_s), 1);
      check("sat_fvec", 32'(fail_vec_s), 0);
      check("sat_pass", 32'(pass_s), 0);

      // Reset in the middle of a faulty sweep
      fault = 1;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (99) @(posedge clk);
      #1;
      check("mid_busy_before", 32'(busy), 1);
      check("mid_fv_before", 32'(fail_valid), 1);
      rst = 1'b1;
      @(posedge clk); #1;
      check("mid_busy", 32'(busy), 0);
      check("mid_done", 32'(done), 0);
      check("mid_op_a", 32'(op_a), 0);
      check("mid_op_b", 32'(op_b), 0);
      check("mid_err", 32'(err_count), 0);
      check("mid_fv", 32'(fail_valid), 0);
      rst   = 1'b0;
      fault = 0;
      run_sweep(1'b0, cyc);
      check("mid_re_cycles", 32'(cyc), SWEEP);
      check("mid_re_pass", 32'(pass), 1);

      // Start held high: prior errors cleared, no restart while busy
      fault = 1;
      run_sweep(1'b0, cyc);
      check("hold_pre_err", 32'(err_count), N_SUM0);
      fault = 0;
      run_sweep(1'b1, cyc);
      start = 1'b0;
      check("hold_cycles", 32'(cyc), SWEEP);
      check("hold_err", 32'(err_count), 0);
      check("hold_pass", 32'(pass), 1);
      @(posedge clk); #1;
      check("hold_stay_done", 32'(done), 1);
      check("hold_stay_idle", 32'(busy), 0);

      // Adder ignoring carry-in
      fault = 3;
      run_sweep(1'b0, cyc);
      check("cin_cycles", 32'(cyc), SWEEP);
      check("cin_err", 32'(err_count), N_CINIGN);
      check("cin_fv", 32'(fail_valid), (N_CINIGN != 0) ? 1 : 0);
      check("cin_fvec", 32'(fail_vec), 32'(FV_CINIGN));
      check("cin_pass", 32'(pass), (N_CINIGN == 0) ? 1 : 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/adder_bist.md
# adder_bist

Built-in self-test engine for the team's N-bit adder tiles (e.g. the half/full adder projects). It acts as the initiator opposite the adder under test: it drives every operand combination into the DUT, samples the DUT's sum/carry after a fixed latency, compares against an internally computed reference, and reports error count, first failing vector and pass/fail. It sits beside the adder inside the user project wrapper, between the dedicated input pins (start) and output pins (status).

## Interface
- WIDTH, 4, operand width of the adder under test (1..8)
- DUT_LAT, 1, DUT cycles from operand change to valid result (0 = combinational DUT)
- ERR_W, 8, width of the saturating error counter
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  launch a sweep (sampled level, acted on in IDLE/DONE)
- op_a  out  WIDTH  operand A to DUT (registered)
- op_b  out  WIDTH  operand B to DUT (registered)
- op_cin  out  1  carry-in to DUT (registered; constant 0 unless BIST_CIN_EN)
- dut_sum  in  WIDTH  DUT sum result
- dut_cout  in  1  DUT carry-out
- busy  out  1  sweep in progress
- done  out  1  sweep finished, results valid
- pass  out  1  done && err_count == 0
- err_count  out  ERR_W  mismatching vectors, saturating
- fail_valid  out  1  at least one mismatch captured
- fail_vec  out  2*WIDTH+1  first failing {cin, b, a}

## Operation
- States: IDLE, RUN, DONE.
- IDLE: busy=0, done=0, operands 0. start=1 -> RUN; clears err_count, fail_valid, fail_vec, vector counter vec, wait counter.
- RUN: operands driven from vec: a=vec[WIDTH-1:0], b=vec[2*WIDTH-1:WIDTH], cin=vec[2*WIDTH] (BIST_CIN_EN) else 0.
- Wait counter counts 0..DUT_LAT per vector; compare happens on the edge where wait==DUT_LAT.
- Reference: {cout,sum} = a + b + cin, computed at WIDTH+1 bits, no truncation.
- Mismatch on either dut_sum or dut_cout: err_count += 1 unless already all-ones (saturate, no wrap); if fail_valid==0, capture vector into fail_vec and set fail_valid.
- After compare: if vec is last (N_VEC-1) -> DONE; else vec+1, wait=0.
- N_VEC = 2^(2*WIDTH) or 2^(2*WIDTH+1) with BIST_CIN_EN.
- DONE: done=1, results held, operands held at last vector. start=1 -> clear results, RUN (re-run).
- start in RUN: ignored.
- rst at any time, including mid-sweep: next edge all state and outputs to 0, state IDLE.

## Timing
- Reset values: every output 0; state IDLE.
- start sampled high at edge k -> busy=1, op=vector 0 from cycle k+1.
- Each vector occupies exactly DUT_LAT+1 cycles; no gaps between vectors.
- Sweep length N_VEC*(DUT_LAT+1) cycles; busy falls and done rises in the same cycle, immediately after the final compare edge.
- err_count/fail_* update on the compare edge, visible next cycle.
- pass combinational from done and err_count; never 1 while busy.

## Configuration
- BIST_CIN_EN defined: carry-in included in the sweep, vec is 2*WIDTH+1 bits, N_VEC doubled, op_cin toggles.
- BIST_CIN_EN undefined: op_cin tied 0, vec 2*WIDTH bits, fail_vec MSB always 0; targets half-adder tiles without carry-in.

## Test plan
- WIDTH=4, DUT_LAT=1, correct behavioural adder, pulse start -> busy 512 cycles, then done=1, pass=1, err_count=0, fail_valid=0.
- Same, DUT sum[0] stuck-at-0 -> err_count=128, fail_valid=1, fail_vec={0,4'h0,4'h1}, pass=0.
- ERR_W=4, DUT cout stuck-at-1 -> err_count saturates at 15 (no wrap to 0), fail_vec=0 (vector a=0,b=0).
- rst asserted at cycle 100 of a sweep -> next cycle busy=0, done=0, op_a=op_b=0, err_count=0; fresh start completes normally in 512 cycles.
- start held high throughout the sweep -> no restart while busy; after done, next start edge re-runs and clears prior err_count.
- BIST_CIN_EN defined, DUT ignoring cin -> 1024-cycle sweep, err_count=256, fail_vec={1,4'h0,4'h0}.
